// File: rtl/issue_stage_pkg.sv
// Shared types for the issue latch: tags, decoder and issue packets.
// Also holds the source-operand select helper.
package issue_stage_pkg;

    localparam int DATA_W = 32;
    localparam int PHYS_W = 6;
    localparam int RS_W = 4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef logic [PHYS_W-1:0] phys_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND,
        ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
    } alu_func_t;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_BR   = 2'd2,
        FU_MEM  = 2'd3
    } fu_class_t;

    typedef struct packed {
        phys_idx_t phys_reg;
    } tag_t;

    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        tag_t            t1;
        tag_t            t2;
        tag_t            dest;
        logic [RS_W-1:0] rs_idx;
        alu_func_t       alu_func;
        logic            rd_mem;
        logic            wr_mem;
        logic            cond_branch;
        logic            uncond_branch;
    } decoder_packet_t;

    typedef struct packed {
        logic            issue_en;
        decoder_packet_t decoder_packet;
    } rs_is_packet_t;

    typedef struct packed {
        logic            valid;
        logic            fire;
        fu_class_t       fu_class;
        decoder_packet_t decoder_packet;
        word_t           opa;
        word_t           opb;
    } is_ex_packet_t;

    function automatic decoder_packet_t nop_packet();
        decoder_packet_t p;
        p = '0;
        p.inst = NOP_INST;
        p.alu_func = ALU_ADD;
        return p;
    endfunction

    // p0 is hardwired zero; a live CDB broadcast beats the stale PRF read
    function automatic word_t pick_operand(
        input phys_idx_t idx,
        input logic      cdb_en,
        input phys_idx_t cdb_idx,
        input word_t     cdb_val,
        input word_t     prf_val
    );
        if (idx == '0)
            return '0;
        else if (cdb_en && cdb_idx == idx)
            return cdb_val;
        else
            return prf_val;
    endfunction

endpackage

// File: rtl/issue_stage_if.sv
// Bus bundle around the issue latch: RS side, CDB, PRF ports, FU side.
// master is the issue stage itself; slave is its environment.
interface issue_stage_if #(
    parameter int XLEN = 32,
    parameter int STALL_CNT_W = 32
);
    import issue_stage_pkg::*;

    rs_is_packet_t          rs_is_packet;
    tag_t                   cdb;
    logic                   cdb_en;
    logic [XLEN-1:0]        cdb_value;
    phys_idx_t              prf_rd1_idx;
    phys_idx_t              prf_rd2_idx;
    logic [XLEN-1:0]        prf_rd1_val;
    logic [XLEN-1:0]        prf_rd2_val;
    logic [3:0]             fu_busy;
    logic                   is_stall;
    is_ex_packet_t          is_ex_packet;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        input  rs_is_packet, cdb, cdb_en, cdb_value,
        input  prf_rd1_val, prf_rd2_val, fu_busy,
        output prf_rd1_idx, prf_rd2_idx,
        output is_stall, is_ex_packet, stall_cycles
    );

    modport slave (
        output rs_is_packet, cdb, cdb_en, cdb_value,
        output prf_rd1_val, prf_rd2_val, fu_busy,
        input  prf_rd1_idx, prf_rd2_idx,
        input  is_stall, is_ex_packet, stall_cycles
    );

endinterface

// File: rtl/fu_class_decode.sv
// Maps a decoded instruction onto the functional unit class that runs it.
// Memory beats branch beats multiply; everything else is plain ALU.
module fu_class_decode
    import issue_stage_pkg::*;
(
    input  decoder_packet_t pkt,
    output fu_class_t       fu_class
);

    logic unused_bits;
    assign unused_bits = ^{pkt.valid, pkt.inst, pkt.t1, pkt.t2,
                           pkt.dest, pkt.rs_idx};

    // priority classification of the incoming instruction
    always_comb begin
        fu_class = FU_ALU;
        if (pkt.rd_mem || pkt.wr_mem)
            fu_class = FU_MEM;
        else if (pkt.cond_branch || pkt.uncond_branch)
            fu_class = FU_BR;
        else if (pkt.alu_func inside {ALU_MUL, ALU_MULH,
                                      ALU_MULHSU, ALU_MULHU})
            fu_class = FU_MULT;
    end

endmodule

// File: rtl/issue_stage.sv
// Single-entry issue latch between the reservation station and execute.
// Reads operands with CDB bypass at accept and holds them until the FU takes them.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STALL_CNT_W = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          interrupt,
    issue_stage_if.master bus
);

    typedef enum logic {EMPTY, HELD} state_t;

    state_t                 state;
    state_t                 state_nxt;
    decoder_packet_t        in_pkt;
    fu_class_t              in_class;
    decoder_packet_t        held_pkt;
    fu_class_t              held_class;
    word_t                  held_opa;
    word_t                  held_opb;
    logic [XLEN-1:0]        opa_nxt;
    logic [XLEN-1:0]        opb_nxt;
    logic                   held_valid;
    logic                   fire;
    logic                   accept;
    is_ex_packet_t          ex;
    logic [STALL_CNT_W-1:0] stall_cnt;

    assign in_pkt = bus.rs_is_packet.decoder_packet;
    assign bus.prf_rd1_idx = in_pkt.t1.phys_reg;
    assign bus.prf_rd2_idx = in_pkt.t2.phys_reg;
    assign bus.stall_cycles = stall_cnt;
    assign bus.is_ex_packet = ex;

    fu_class_decode u_decode (
        .pkt      (in_pkt),
        .fu_class (in_class)
    );

    // source operands as seen this cycle, with same-cycle CDB bypass
    always_comb begin
        opa_nxt = pick_operand(in_pkt.t1.phys_reg, bus.cdb_en,
                               bus.cdb.phys_reg, bus.cdb_value,
                               bus.prf_rd1_val);
        opb_nxt = pick_operand(in_pkt.t2.phys_reg, bus.cdb_en,
                               bus.cdb.phys_reg, bus.cdb_value,
                               bus.prf_rd2_val);
    end

    // stall/fire and the execute packet, from held state and fu_busy only
    always_comb begin
        held_valid = (state == HELD);
        fire = held_valid && !bus.fu_busy[held_class];
        bus.is_stall = held_valid && bus.fu_busy[held_class];
        ex.valid = held_valid;
        ex.fire = fire;
        ex.fu_class = FU_ALU;
        ex.decoder_packet = nop_packet();
        ex.opa = '0;
        ex.opb = '0;
        if (held_valid) begin
            ex.fu_class = held_class;
            ex.decoder_packet = held_pkt;
            ex.opa = held_opa;
            ex.opb = held_opb;
        end
    end

    // must mirror the RS marking rule, plus the flush
    assign accept = bus.rs_is_packet.issue_en && !bus.is_stall && !interrupt;

    // next state: flush, load, drain or hold
    always_comb begin
        state_nxt = state;
        if (interrupt)
            state_nxt = EMPTY;
        else if (accept)
            state_nxt = HELD;
        else if (fire)
            state_nxt = EMPTY;
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // payload is captured only at accept and frozen while held
    always_ff @(posedge clock) begin
        if (accept) begin
            held_pkt <= in_pkt;
            held_class <= in_class;
            held_opa <= opa_nxt;
            held_opb <= opb_nxt;
        end
    end

    // saturating stall counter, survives interrupts
    always_ff @(posedge clock) begin
        if (reset)
            stall_cnt <= '0;
        else if (bus.is_stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end

endmodule

// File: tb/tb_issue_stage.sv
// Testbench for issue_stage: directed scenarios plus random traffic.
// Outputs are compared each cycle against a behavioural one-entry model.
module tb_issue_stage;
    import issue_stage_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic interrupt;

    always #5 clock = ~clock;

    issue_stage_if #(.XLEN(32), .STALL_CNT_W(32)) bus ();

    issue_stage #(.XLEN(32), .STALL_CNT_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .interrupt (interrupt),
        .bus       (bus)
    );

    word_t prf_mem [64];

    always_comb begin
        bus.prf_rd1_val = prf_mem[bus.prf_rd1_idx];
        bus.prf_rd2_val = prf_mem[bus.prf_rd2_idx];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: at most one instruction in flight
    bit              m_valid;
    decoder_packet_t m_pkt;
    word_t           m_opa;
    word_t           m_opb;
    fu_class_t       m_class;
    logic [31:0]     m_stalls;

    function automatic fu_class_t ref_class(input decoder_packet_t p);
        if (p.rd_mem | p.wr_mem) return FU_MEM;
        if (p.cond_branch | p.uncond_branch) return FU_BR;
        case (p.alu_func)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: return FU_MULT;
            default: return FU_ALU;
        endcase
    endfunction

    function automatic word_t ref_opnd(input phys_idx_t r, input bit cen,
                                       input phys_idx_t ct, input word_t cv);
        if (r == 0) return 32'd0;
        if (cen && ct == r) return cv;
        return prf_mem[r];
    endfunction

    function automatic decoder_packet_t mk(input alu_func_t f,
                                           input phys_idx_t a,
                                           input phys_idx_t b,
                                           input logic [3:0] kind,
                                           input logic [31:0] inst);
        decoder_packet_t p;
        p = '0;
        p.valid = 1'b1;
        p.inst = inst;
        p.t1.phys_reg = a;
        p.t2.phys_reg = b;
        p.dest.phys_reg = phys_idx_t'($urandom_range(1, 63));
        p.rs_idx = 4'($urandom_range(0, 15));
        p.alu_func = f;
        p.rd_mem = kind[0];
        p.wr_mem = kind[1];
        p.cond_branch = kind[2];
        p.uncond_branch = kind[3];
        return p;
    endfunction

    function automatic phys_idx_t rand_reg();
        if ($urandom_range(0, 3) == 0) return '0;
        return phys_idx_t'($urandom_range(1, 63));
    endfunction

    function automatic decoder_packet_t rand_pkt();
        logic [3:0] kind;
        int k;
        k = $urandom_range(0, 9);
        kind = 4'b0000;
        if (k == 0) kind = 4'b0001;
        if (k == 1) kind = 4'b0010;
        if (k == 2) kind = 4'b0100;
        if (k == 3) kind = 4'b1000;
        if (k == 4) kind = 4'b0101;
        return mk(alu_func_t'($urandom_range(0, 13)), rand_reg(), rand_reg(),
                  kind, $urandom);
    endfunction

    // one clock: drive at negedge, compare, advance model, wait posedge
    task automatic step(input bit rst, input bit irq, input bit en,
                        input decoder_packet_t p, input logic [3:0] busy,
                        input bit cen, input phys_idx_t ct, input word_t cv,
                        input bit mutate);
        bit exp_stall;
        bit exp_fire;
        @(negedge clock);
        if (mutate) prf_mem[$urandom_range(1, 63)] = $urandom;
        reset = rst;
        interrupt = irq;
        bus.rs_is_packet.issue_en = en;
        bus.rs_is_packet.decoder_packet = p;
        bus.fu_busy = busy;
        bus.cdb_en = cen;
        bus.cdb.phys_reg = ct;
        bus.cdb_value = cv;
        #1;
        exp_stall = m_valid && busy[m_class];
        exp_fire = m_valid && !busy[m_class];
        check("is_stall", bus.is_stall, exp_stall);
        check("valid", bus.is_ex_packet.valid, m_valid);
        check("fire", bus.is_ex_packet.fire, exp_fire);
        check("fu_class", bus.is_ex_packet.fu_class,
              m_valid ? m_class : FU_ALU);
        check("opa", bus.is_ex_packet.opa, m_valid ? m_opa : 32'd0);
        check("opb", bus.is_ex_packet.opb, m_valid ? m_opb : 32'd0);
        check("pkt", bus.is_ex_packet.decoder_packet,
              m_valid ? m_pkt : nop_packet());
        check("stall_cycles", bus.stall_cycles, m_stalls);
        check("rd1_idx", bus.prf_rd1_idx, p.t1.phys_reg);
        check("rd2_idx", bus.prf_rd2_idx, p.t2.phys_reg);
        if (rst) begin
            m_valid = 0;
            m_stalls = 0;
        end else begin
            if (exp_stall && m_stalls != 32'hffff_ffff) m_stalls++;
            if (irq) begin
                m_valid = 0;
            end else if (en && !exp_stall) begin
                m_valid = 1;
                m_pkt = p;
                m_class = ref_class(p);
                m_opa = ref_opnd(p.t1.phys_reg, cen, ct, cv);
                m_opb = ref_opnd(p.t2.phys_reg, cen, ct, cv);
            end else if (exp_fire) begin
                m_valid = 0;
            end
        end
        @(posedge clock);
    endtask

    decoder_packet_t idle;
    decoder_packet_t pk;
    decoder_packet_t other;

    initial begin
        for (int i = 0; i < 64; i++) prf_mem[i] = $urandom;
        prf_mem[5] = 32'd7;
        prf_mem[9] = 32'd0;
        idle = nop_packet();
        reset = 1'b1;
        interrupt = 1'b0;
        bus.rs_is_packet = '0;
        bus.fu_busy = 4'b0;
        bus.cdb_en = 1'b0;
        bus.cdb = '0;
        bus.cdb_value = '0;
        repeat (2) @(posedge clock);
        m_valid = 0;
        m_stalls = 0;

        // ALU add, t1=p5 (7), t2=p0
        pk = mk(ALU_ADD, 6'd5, 6'd0, 4'b0000, 32'h0000_0101);
        step(0, 0, 1, pk, 4'b0000, 0, 6'd0, 32'd0, 0);
        #1;
        check("alu_valid", bus.is_ex_packet.valid, 1'b1);
        check("alu_fire", bus.is_ex_packet.fire, 1'b1);
        check("alu_opa", bus.is_ex_packet.opa, 32'd7);
        check("alu_opb", bus.is_ex_packet.opb, 32'd0);
        check("alu_class", bus.is_ex_packet.fu_class, FU_ALU);

        // CDB bypass on t1, then on both sources
        pk = mk(ALU_ADD, 6'd9, 6'd5, 4'b0000, 32'h0000_0102);
        step(0, 0, 1, pk, 4'b0000, 1, 6'd9, 32'h55, 0);
        #1;
        check("byp_opa", bus.is_ex_packet.opa, 32'h55);
        check("byp_opb", bus.is_ex_packet.opb, 32'd7);
        pk = mk(ALU_SUB, 6'd9, 6'd9, 4'b0000, 32'h0000_0103);
        step(0, 0, 1, pk, 4'b0000, 1, 6'd9, 32'h66, 0);
        #1;
        check("byp2_opa", bus.is_ex_packet.opa, 32'h66);
        check("byp2_opb", bus.is_ex_packet.opb, 32'h66);
        step(0, 0, 0, idle, 4'b0000, 0, 6'd0, 32'd0, 0);

        // MUL stalled three cycles while the RS keeps offering
        pk = mk(ALU_MUL, 6'd5, 6'd5, 4'b0000, 32'h0000_0200);
        other = mk(ALU_ADD, 6'd1, 6'd2, 4'b0000, 32'h0000_0201);
        step(0, 0, 1, pk, 4'b0000, 0, 6'd0, 32'd0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, other, 4'b0010, 0, 6'd0, 32'd0, 0);
        #1;
        check("mul_held_inst", bus.is_ex_packet.decoder_packet.inst,
              32'h0000_0200);
        check("mul_stall_cnt", bus.stall_cycles, 32'd3);
        step(0, 0, 0, idle, 4'b0000, 0, 6'd0, 32'd0, 0);
        step(0, 0, 0, idle, 4'b0000, 0, 6'd0, 32'd0, 0);

        // four back-to-back ALU ops, no bubble
        for (int i = 0; i < 4; i++) begin
            pk = mk(ALU_ADD, rand_reg(), rand_reg(), 4'b0000, 32'h300 + i);
            step(0, 0, 1, pk, 4'b0000, 0, 6'd0, 32'd0, 0);
            #1;
            check("b2b_fire", bus.is_ex_packet.fire, 1'b1);
            check("b2b_inst", bus.is_ex_packet.decoder_packet.inst,
                  32'h300 + i);
        end
        step(0, 0, 0, idle, 4'b0000, 0, 6'd0, 32'd0, 0);

        // stalled MEM op flushed by interrupt
        pk = mk(ALU_ADD, 6'd5, 6'd0, 4'b0001, 32'h0000_0400);
        step(0, 0, 1, pk, 4'b0000, 0, 6'd0, 32'd0, 0);
        step(0, 0, 0, idle, 4'b1000, 0, 6'd0, 32'd0, 0);
        step(0, 0, 0, idle, 4'b1000, 0, 6'd0, 32'd0, 0);
        step(0, 1, 1, pk, 4'b1000, 0, 6'd0, 32'd0, 0);
        #1;
        check("irq_valid", bus.is_ex_packet.valid, 1'b0);
        check("irq_stall", bus.is_stall, 1'b0);
        check("irq_cnt_kept", bus.stall_cycles, 32'd6);

        // reset during a stalled branch
        pk = mk(ALU_ADD, 6'd5, 6'd5, 4'b0100, 32'h0000_0500);
        step(0, 0, 1, pk, 4'b0000, 0, 6'd0, 32'd0, 0);
        step(0, 0, 0, idle, 4'b0100, 0, 6'd0, 32'd0, 0);
        step(1, 0, 0, idle, 4'b0100, 0, 6'd0, 32'd0, 0);
        #1;
        check("rst_valid", bus.is_ex_packet.valid, 1'b0);
        check("rst_stall", bus.is_stall, 1'b0);
        check("rst_fire", bus.is_ex_packet.fire, 1'b0);
        check("rst_cnt", bus.stall_cycles, 32'd0);
        check("rst_opa", bus.is_ex_packet.opa, 32'd0);
        check("rst_class", bus.is_ex_packet.fu_class, FU_ALU);
        check("rst_inst", bus.is_ex_packet.decoder_packet.inst, NOP_INST);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            phys_idx_t ct;
            int sel;
            pk = rand_pkt();
            sel = $urandom_range(0, 2);
            ct = (sel == 0) ? pk.t1.phys_reg :
                 (sel == 1) ? pk.t2.phys_reg : rand_reg();
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0),
                 pk,
                 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1), ct, $urandom, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_stage.md
# issue_stage

Single-entry issue latch between the reservation station and execute. Captures the instruction the RS selects, reads both source operands from the physical register file with same-cycle CDB bypass, and presents a complete operand packet to the target functional unit. Asserts `is_stall` back to the RS while the held instruction's functional unit cannot accept it. Flushes on interrupt.

## Interface
- `XLEN`, 32: operand width.
- `STALL_CNT_W`, 32: width of the stall performance counter.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `interrupt` in 1: flush request, synchronous.
- `rs_is_packet` in RS_IS_PACKET: `issue_en`, plus a `decoder_packet` carrying `t1`/`t2` TAGs, `dest`, `rs_idx`, `alu_func`, `rd_mem`/`wr_mem` and branch flags.
- `cdb` in TAG: tag currently being broadcast.
- `cdb_en` in 1: CDB broadcast valid.
- `cdb_value` in XLEN: value carried with `cdb`.
- `prf_rd1_idx` out PHYS_IDX: PRF read port 1 index, driven from `rs_is_packet.decoder_packet.t1.phys_reg`.
- `prf_rd2_idx` out PHYS_IDX: PRF read port 2 index, driven from `t2.phys_reg`.
- `prf_rd1_val` in XLEN: combinational PRF read data for port 1.
- `prf_rd2_val` in XLEN: combinational PRF read data for port 2.
- `fu_busy` in 4: busy flags indexed by FU_CLASS {ALU=0, MULT=1, BR=2, MEM=3}.
- `is_stall` out 1: the latch cannot accept an instruction this cycle.
- `is_ex_packet` out IS_EX_PACKET: `valid`, `fire`, `fu_class`, `decoder_packet`, `opa`, `opb`.
- `stall_cycles` out STALL_CNT_W: saturating count of cycles with `is_stall` high.

## Operation
- State is one entry: `held_valid`, `held_pkt`, `held_opa`, `held_opb`, `held_class`.
- Two states:
  - EMPTY: `held_valid=0`.
  - HELD: `held_valid=1`.
- FU class decode, in priority order:
  - `rd_mem|wr_mem` → MEM.
  - else `cond_branch|uncond_branch` → BR.
  - else `alu_func` ∈ {MUL, MULH, MULHSU, MULHU} → MULT.
  - else ALU.
- Operand selection, per source:
  - If `phys_reg==0`, the operand is 0.
  - Else if `cdb_en && cdb.phys_reg==phys_reg`, the operand is `cdb_value`.
  - Else the operand is `prf_rdN_val`.
- `fire = held_valid && !fu_busy[held_class]`. Execute consumes the entry in any cycle where `fire=1`.
- `is_stall = held_valid && fu_busy[held_class]`. It depends only on registered state and `fu_busy`, never on `rs_is_packet`, so no combinational loop is formed with the RS.
- `accept = rs_is_packet.issue_en && !is_stall && !interrupt`.
  - This must match the RS's own marking rule (the RS marks its entry issued when `issue_en && !is_stall`) exactly.
  - Otherwise an instruction is lost or duplicated.
- Next state:
  - `accept`: load a new entry (EMPTY→HELD, or HELD→HELD replacing a firing entry).
  - `fire && !accept`: HELD→EMPTY.
  - Stalled: hold; operands frozen.
- Operand values are captured only at accept. They are never re-bypassed while held, because the RS only issues ready operands.
- `interrupt` or `reset`:
  - Next state EMPTY.
  - Payload registers are don't-care, but `is_ex_packet.decoder_packet.valid` and `inst` read 0 and `NOP` while EMPTY.
- `stall_cycles`:
  - Increments on each cycle with `is_stall=1`.
  - Saturates at all-ones.
  - Cleared by `reset` only; `interrupt` does not clear it.

## Timing
- Latency: RS issue in cycle N → `is_ex_packet.valid=1` in cycle N+1. The earliest `fire` is N+1.
- PRF read and CDB bypass are combinational within cycle N.
- Throughput: one instruction per cycle when the target FUs are free.
- Reset values:
  - `held_valid=0`, `is_stall=0`, `fire=0`, `valid=0`, `stall_cycles=0`.
  - `opa`/`opb` = 0.
  - `fu_class` = ALU.
- Boundary conditions:
  - Fire and accept in the same cycle: the new entry replaces the old one with no bubble.
  - `interrupt` while HELD and `fire=1`: the flush wins, and execute must ignore a `fire` in a cycle where `interrupt=1`.
  - A CDB broadcast matching both sources bypasses both sources.
  - `reset` mid-stall: EMPTY on the next cycle and `is_stall=0`.

## Structure
- `FU_CLASS` enum and `IS_EX_PACKET` typedef go in `sys_defs.svh`.
- Sub-module `fu_class_decode`: combinational, DECODER_PACKET → FU_CLASS. It is reused by the dispatch-side RS index logic.
- The rest is flat: the operand mux, the state register and the counter.

## Test plan
- Issue ALU add with t1=p5 (PRF=7) and t2=p0, `fu_busy=0` → next cycle `valid=1`, `fire=1`, `opa=7`, `opb=0`, `fu_class=ALU`.
- Issue with t1=p9 while `cdb_en=1`, `cdb=p9`, `cdb_value=0x55` and PRF p9 stale=0 → `opa=0x55`.
- Issue MUL, then hold `fu_busy[1]=1` for 3 cycles → `is_stall=1` for 3 cycles, the packet is unchanged, `stall_cycles=3`, and a concurrent `issue_en` is not accepted.
- Back-to-back ALU issues on 4 consecutive cycles with FUs free → 4 consecutive `fire` cycles, in order, with no bubble.
- HELD and stalled MEM op, then `interrupt` for 1 cycle → `valid=0` and `is_stall=0` next cycle, and `stall_cycles` is retained.
- `reset` asserted during a stalled BR → the next cycle shows all outputs at their reset values.
